// File: rtl/fft_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_frame_loader: packs offset-binary ADC samples into double-buffered   |
// | complex frames for the radix-2 FFT.               Revision: 1.0          |
// +--------------------------------------------------------------------------+
module fft_frame_loader #(
  parameter int SIZE  = 64,
  parameter int IN_N  = 12,
  parameter int RN    = 16,
  parameter int SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [IN_N-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         restart,
  output logic [SIZE-1:0][1:0][RN-1:0] out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  drop_frames
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  typedef logic [SIZE-1:0][1:0][RN-1:0] frame_t;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  frame_t           fill_buf_q, fill_buf_d;
  frame_t           out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      drop_q, drop_d;

  logic             accept;
  logic             slot_free;
  logic             frame_done;
  logic             swap;

  logic signed [IN_N-1:0] sample_s;
  logic signed [RN-1:0]   sample_ext;
  logic signed [RN-1:0]   sample_conv;

  // Offset binary to two's complement is just an MSB flip.
  assign sample_s    = {~in_data[IN_N-1], in_data[IN_N-2:0]};
  assign sample_ext  = RN'(sample_s);
  assign sample_conv = sample_ext <<< SHIFT;

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_buf_q <= fill_buf_d;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_buf_d  = fill_buf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;

    accept     = in_valid && in_ready;
    slot_free  = !out_valid_q || out_ready;
    frame_done = accept && (idx_q == LAST_IDX);
    // A completing sample goes straight to the output when the slot is free,
    // so a frame costs no extra cycle in FULL.
    swap       = (frame_done || ((state_q == ST_FULL) && !restart)) && slot_free;

    if (accept) begin
      fill_buf_d[idx_q][0] = sample_conv;
      fill_buf_d[idx_q][1] = '0;
    end

    if (restart) begin
      idx_d   = '0;
      state_d = ST_FILL;
      if (((idx_q != '0) || (state_q == ST_FULL)) && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (accept) begin
      idx_d = frame_done ? '0 : idx_q + 1'b1;
      if (frame_done && !swap) begin
        state_d = ST_FULL;
      end
    end else if (swap) begin
      state_d = ST_FILL;
    end

    if (swap) begin
      out_d       = fill_buf_d;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    in_ready = (state_q == ST_FILL) && !restart;
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign drop_frames = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
`default_nettype none
// Self-checking bench for fft_frame_loader (SIZE=4) against a queue-based frame model.
module tb_fft_frame_loader;

  localparam int SIZE  = 4;
  localparam int IN_N  = 12;
  localparam int RN    = 16;
  localparam int SHIFT = 3;

  typedef logic [SIZE-1:0][1:0][RN-1:0] frame_t;

  logic            clk = 1'b0;
  logic            n_reset;
  logic [IN_N-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            restart;
  frame_t          out;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     drop_frames;

  fft_frame_loader #(.SIZE(SIZE), .IN_N(IN_N), .RN(RN), .SHIFT(SHIFT)) dut (
    .clk(clk), .n_reset(n_reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .drop_frames(drop_frames)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;

  // Reference model: accepted samples of the partial frame, a held full frame,
  // the presented frame, and the drop counter.
  int     m_part[$];
  bit     m_full;
  frame_t m_held;
  frame_t m_out;
  bit     m_ov;
  int     m_drop;
  bit     m_ir;
  logic   s_ir;

  function automatic logic [RN-1:0] conv(input int x);
    int v;
    v = (x - (1 << (IN_N - 1))) * (1 << SHIFT);
    return v[RN-1:0];
  endfunction

  function automatic frame_t mk_frame(input int q[$]);
    frame_t f;
    f = '0;
    for (int i = 0; i < q.size() && i < SIZE; i++) f[i][0] = conv(q[i]);
    return f;
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_full = 0;
    m_ov   = 0;
    m_drop = 0;
    m_out  = '0;
    m_held = '0;
  endtask

  // One clock: apply inputs, sample combinational in_ready, advance model, clock.
  task automatic tick(input bit v, input int d, input bit rs, input bit rdy);
    bit fresh;
    bit slot;
    in_valid  = v;
    in_data   = d[IN_N-1:0];
    restart   = rs;
    out_ready = rdy;
    #1;
    s_ir  = in_ready;
    m_ir  = !m_full && !rs;
    fresh = 0;
    slot  = !m_ov || rdy;
    if (rs) begin
      if ((m_part.size() != 0 || m_full) && m_drop < 65535) m_drop++;
      m_part.delete();
      m_full = 0;
    end else if (v && m_ir) begin
      m_part.push_back(d);
      if (m_part.size() == SIZE) begin
        if (slot) begin
          m_out = mk_frame(m_part);
          fresh = 1;
        end else begin
          m_held = mk_frame(m_part);
          m_full = 1;
        end
        m_part.delete();
      end
    end else if (m_full && slot) begin
      m_out  = m_held;
      m_full = 0;
      fresh  = 1;
    end
    if (fresh) m_ov = 1;
    else if (m_ov && rdy) m_ov = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = '0; restart = 0; out_ready = 0;
    n_reset = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_reset = 0;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = '0; restart = 0; out_ready = 0;
    n_reset = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (drop_frames !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_frames); end
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out); end
    n_reset = 0;
    tick(0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_ov: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    int     data[4];
    frame_t exp_f;
    data = '{12'h800, 12'hFFF, 12'h000, 12'h801};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, data[i], 0, 1);
      n_cmp++; if (s_ir !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready[%0d]: got %b want 1", i, s_ir); end
      if (i == 2) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_ov: got %b want 0", out_valid); end
      end
    end
    exp_f = '0;
    exp_f[0][0] = 16'd0;
    exp_f[1][0] = 16'd16376;
    exp_f[2][0] = 16'hC000;
    exp_f[3][0] = 16'd8;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_ov: got %b want 1", out_valid); end
    n_cmp++; if (out !== exp_f) begin n_bad++; $display("FAIL basic_frame: got %h want %h", out, exp_f); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 3 * SIZE; i++) begin
      tick(1, $urandom_range(0, 4095), 0, 0);
      n_cmp++; if (s_ir !== m_ir) begin n_bad++; $display("FAIL hold_in_ready[%0d]: got %b want %b", i, s_ir, m_ir); end
      n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL hold_ov[%0d]: got %b want %b", i, out_valid, m_ov); end
      n_cmp++; if (out !== m_out) begin n_bad++; $display("FAIL hold_out[%0d]: got %h want %h", i, out, m_out); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_full_ready: got %b want 0", in_ready); end
    tick(0, 0, 0, 1);
    n_cmp++; if (out !== m_held) begin n_bad++; $display("FAIL hold_second_frame: got %h want %h", out, m_held); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_second_ov: got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready_back: got %b want 1", in_ready); end
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    int     frames;
    int     q[$];
    frame_t exp_f;
    do_reset();
    frames = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1, i, 0, 1);
      n_cmp++; if (s_ir !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, s_ir); end
      n_cmp++; if (out_valid !== ((i + 1) % SIZE == 0)) begin n_bad++; $display("FAIL b2b_ov[%0d]: got %b want %b", i, out_valid, ((i + 1) % SIZE == 0)); end
      if (out_valid === 1'b1) begin
        q.delete();
        for (int j = 0; j < SIZE; j++) q.push_back(frames * SIZE + j);
        exp_f = mk_frame(q);
        n_cmp++; if (out !== exp_f) begin n_bad++; $display("FAIL b2b_frame[%0d]: got %h want %h", frames, out, exp_f); end
        frames++;
      end
    end
    n_cmp++; if (frames !== 256 / SIZE) begin n_bad++; $display("FAIL b2b_frame_count: got %0d want %0d", frames, 256 / SIZE); end
  endtask

  task automatic test_restart();
    int     q[$];
    frame_t exp_f;
    do_reset();
    tick(1, $urandom_range(0, 4095), 0, 1);
    tick(1, $urandom_range(0, 4095), 0, 1);
    tick(1, 12'h123, 1, 1);
    n_cmp++; if (s_ir !== 1'b0) begin n_bad++; $display("FAIL restart_in_ready: got %b want 0", s_ir); end
    n_cmp++; if (drop_frames !== 16'd1) begin n_bad++; $display("FAIL restart_drop: got %0d want 1", drop_frames); end
    tick(0, 0, 1, 1);
    n_cmp++; if (drop_frames !== 16'd1) begin n_bad++; $display("FAIL restart_idle_drop: got %0d want 1", drop_frames); end
    for (int i = 0; i < SIZE; i++) begin
      q.push_back($urandom_range(0, 4095));
      tick(1, q[i], 0, 1);
    end
    exp_f = mk_frame(q);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL restart_frame_ov: got %b want 1", out_valid); end
    n_cmp++; if (out !== exp_f) begin n_bad++; $display("FAIL restart_frame: got %h want %h", out, exp_f); end
    n_cmp++; if (drop_frames !== m_drop[15:0]) begin n_bad++; $display("FAIL restart_model_drop: got %0d want %0d", drop_frames, m_drop); end
  endtask

  task automatic test_restart_full();
    frame_t held;
    int     q[$];
    do_reset();
    for (int i = 0; i < 2 * SIZE; i++) tick(1, $urandom_range(0, 4095), 0, 0);
    held = m_out;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rfull_is_full: got %b want 0", in_ready); end
    tick(0, 0, 1, 0);
    n_cmp++; if (drop_frames !== 16'd1) begin n_bad++; $display("FAIL rfull_drop: got %0d want 1", drop_frames); end
    n_cmp++; if (out !== held) begin n_bad++; $display("FAIL rfull_out_held: got %h want %h", out, held); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rfull_ov: got %b want 1", out_valid); end
    restart = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rfull_ready: got %b want 1", in_ready); end
    for (int i = 0; i < SIZE; i++) begin
      q.push_back($urandom_range(0, 4095));
      tick(1, q[i], 0, 0);
    end
    tick(0, 0, 0, 1);
    n_cmp++; if (out !== mk_frame(q)) begin n_bad++; $display("FAIL rfull_next_frame: got %h want %h", out, mk_frame(q)); end
    n_cmp++; if (out !== m_out) begin n_bad++; $display("FAIL rfull_model_frame: got %h want %h", out, m_out); end
  endtask

  task automatic test_async_reset();
    int q[$];
    do_reset();
    tick(1, $urandom_range(0, 4095), 0, 0);
    tick(1, $urandom_range(0, 4095), 0, 0);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 2 * SIZE + 1; i++) tick(1, $urandom_range(0, 4095), 0, 0);
    in_valid = 0; restart = 0;
    #2;
    n_reset = 1;
    model_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_hold_ov: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_hold_ready: got %b want 1", in_ready); end
    n_cmp++; if (drop_frames !== 16'd0) begin n_bad++; $display("FAIL areset_hold_drop: got %0d want 0", drop_frames); end
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL areset_hold_out: got %h want 0", out); end
    @(posedge clk); #1;
    n_reset = 0;
    tick(1, $urandom_range(0, 4095), 0, 1);
    tick(1, $urandom_range(0, 4095), 0, 1);
    in_valid = 0;
    #2;
    n_reset = 1;
    model_reset();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_fill_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_reset = 0;
    for (int i = 0; i < SIZE; i++) begin
      q.push_back($urandom_range(0, 4095));
      tick(1, q[i], 0, 1);
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_frame_ov: got %b want 1", out_valid); end
    n_cmp++; if (out !== mk_frame(q)) begin n_bad++; $display("FAIL areset_frame: got %h want %h", out, mk_frame(q)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_restart();
    test_restart_full();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
